dot_operand_loader: RTL and testbench
=====================================

Name: dot_operand_loader

Overview:
- Element-serial producer for the NPU's packed-vector dot-product datapath.
- Accepts (x_i, w_i) operand pairs one per cycle on a valid/ready stream and assembles them into N-lane packed x and w vectors.
- Presents each completed vector pair on a valid/ready output feeding the dot-product unit.
- Two ping-pong buffers let one vector fill while the previous one waits to be consumed.

Parameters:
- N, 4, lanes per vector (N >= 1)
- DATA_WIDTH, `DATA_WIDTH, signed element width

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous active-high reset
- s_valid  input  1  operand pair valid
- s_ready  output  1  loader can accept a pair this cycle
- s_x  input  DATA_WIDTH  signed x element
- s_w  input  DATA_WIDTH  signed w element
- s_last  input  1  final element of the current vector (short vector)
- m_valid  output  1  packed vector pair available
- m_ready  input  1  downstream accepts the vector pair
- m_x  output  N*DATA_WIDTH  packed x; lane i at [i*DATA_WIDTH +: DATA_WIDTH]
- m_w  output  N*DATA_WIDTH  packed w; same lane layout
- m_count  output  $clog2(N+1)  number of populated lanes, 1..N

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values:
  - s_ready=1, m_valid=0, m_x=0, m_w=0, m_count=0.
  - Both buffers empty; write select = 0; read select = 0; lane index = 0.
- Input handshake: a pair is accepted when s_valid && s_ready.
  - The accepted pair writes lane[idx] of the write buffer, then idx increments.
- Vector completion: the write buffer closes when the accepted pair has idx==N-1 or s_last=1. On close:
  - buffer full flag set;
  - count stored as idx+1;
  - lanes above idx forced to zero;
  - idx returns to 0;
  - write select toggles.
- s_last on a pair with idx==N-1 is the same as a normal close.
- s_ready = !full[write select].
  - It is 0 only when both buffers hold unconsumed vectors.
  - It does not depend on s_valid.
- Output:
  - m_valid = full[read select].
  - m_x, m_w and m_count come from the read buffer and hold stable while m_valid && !m_ready.
  - m_x, m_w and m_count are zero whenever m_valid=0.
- Output transfer: on m_valid && m_ready, clear full[read select] and toggle read select.
- Latency: m_valid rises the cycle after the closing pair is accepted, if the read side is idle.
- Throughput:
  - One pair accepted per cycle sustained with m_ready=1, so one vector every N cycles, with no bubbles.
  - Closing one buffer and draining the other in the same cycle are both legal.
- Simultaneous events:
  - With both buffers full and m_ready=1 in a cycle, s_ready stays 0 that cycle (registered from full flags) and rises next cycle.
  - A close and a drain of the other buffer in the same cycle both take effect.
- Lane clearing: a buffer's lanes are zeroed when it becomes the write buffer. No stale data from a previous vector may appear in any lane.
- Reset mid-fill or mid-hold: the partial or unconsumed vector is discarded; all state returns to reset values.
- N=1: every accepted pair closes a vector; s_last is irrelevant.
- Arithmetic: none. Values pass through bit-exact with sign preserved; the packed layout matches the dot-product unit's inputs.

Decomposition:
- Shared NPU package holds:
  - the lane-element typedef (signed [DATA_WIDTH-1:0]);
  - the lane-count typedef sized $clog2(N+1);
  - the packed-vector layout helper constant.
- DATA_WIDTH default comes from the common width include.
- One sub-module: operand_slot. It holds one buffer:
  - storage: x/w lane arrays, full flag and count;
  - controls: clear, write-lane, close and drain.
- The top instantiates two slots plus the select/index control.

Test Plan (N=4, DATA_WIDTH=8):
- Reset, then 4 pairs x=1,2,3,4, w=-1,-2,-3,-4 back-to-back, m_ready=1 -> m_valid 1 cycle after 4th accept; m_x=0x04030201, m_w=0xFCFDFEFF, m_count=4.
- Pairs x=5,6 with s_last on 2nd -> m_x=0x00000605, m_w lanes 2-3 zero, m_count=2.
- m_ready=0, send 12 pairs -> s_ready drops after the 8th accept; m_x stable on vector 1. Raise m_ready -> vectors 1, 2, 3 emerge in order, and the 9th pair is accepted only after the first drain.
- Continuous 32 pairs, m_ready=1 -> s_ready never drops; 8 vectors emitted, each 4 cycles apart.
- Send 2 pairs, assert rst for 1 cycle, send 4 pairs x=9 -> only the post-reset vector appears, m_x=0x09090909, with no lanes from the first fill.
- Short vector (1 pair, s_last) followed by a full vector -> the second vector's lanes 1-3 contain the new data, not zeros or leftovers from the first.

Source files
------------

// File: rtl/dot_operand_loader_pkg.sv
// Shared NPU operand types and widths for the packed-vector dot-product path.
// DATA_WIDTH may be overridden by a common width define ahead of this file.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package dot_operand_loader_pkg;
   localparam int DEF_DATA_WIDTH = `DATA_WIDTH;
   localparam int DEF_LANES      = 4;
   // Packed layout: lane i occupies [i*DATA_WIDTH +: DATA_WIDTH], lane 0 at the LSBs.
   localparam int DEF_VEC_WIDTH  = DEF_LANES * DEF_DATA_WIDTH;

   typedef logic signed [DEF_DATA_WIDTH-1:0]  elem_t;
   typedef logic [$clog2(DEF_LANES+1)-1:0]     lane_cnt_t;
endpackage

// File: rtl/dot_operand_loader_operand_slot.sv
// One ping-pong buffer: N x/w lanes, a full flag and the populated-lane count.
// Lanes are zeroed on drain and reset, so an empty slot never carries stale data.
module operand_slot
   import dot_operand_loader_pkg::*;
#(
   parameter int N  = DEF_LANES,
   parameter int DW = DEF_DATA_WIDTH,
   parameter int IW = 2,
   parameter int CW = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_wr,
   input  logic            i_close,
   input  logic            i_drain,
   input  logic [IW-1:0]   i_lane,
   input  logic [DW-1:0]   i_x,
   input  logic [DW-1:0]   i_w,
   output logic            o_full,
   output logic [N*DW-1:0] o_x,
   output logic [N*DW-1:0] o_w,
   output logic [CW-1:0]   o_count
);
   logic [N-1:0][DW-1:0] r_x;
   logic [N-1:0][DW-1:0] r_w;
   logic                 r_full;
   logic [CW-1:0]        r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_drain) begin
         r_x    <= '0;
         r_w    <= '0;
         r_full <= 1'b0;
         r_cnt  <= '0;
      end else if (i_wr) begin
         for (int j = 0; j < N; j++) begin
            if (j == int'(i_lane)) begin
               r_x[j] <= i_x;
               r_w[j] <= i_w;
            end else if (i_close && j > int'(i_lane)) begin
               r_x[j] <= '0;
               r_w[j] <= '0;
            end
         end
         if (i_close) begin
            r_full <= 1'b1;
            r_cnt  <= CW'(i_lane) + CW'(1);
         end
      end
   end

   assign o_full  = r_full;
   assign o_x     = r_x;
   assign o_w     = r_w;
   assign o_count = r_cnt;
endmodule

// File: rtl/dot_operand_loader.sv
// Element-serial loader: packs (x,w) pairs into N-lane vectors through two
// ping-pong slots and presents them on a valid/ready stream.
module dot_operand_loader
   import dot_operand_loader_pkg::*;
#(
   parameter int N          = DEF_LANES,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [DATA_WIDTH-1:0]      s_x,
   input  logic [DATA_WIDTH-1:0]      s_w,
   input  logic                       s_last,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [N*DATA_WIDTH-1:0]    m_x,
   output logic [N*DATA_WIDTH-1:0]    m_w,
   output logic [$clog2(N+1)-1:0]     m_count
);
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(N+1);
   localparam int VW = N * DATA_WIDTH;

   logic               r_wsel;
   logic               r_rsel;
   logic [IW-1:0]      r_idx;
   logic               w_acc;
   logic               w_close;
   logic               w_drain;
   logic [1:0]         w_full;
   logic [1:0][VW-1:0] w_x;
   logic [1:0][VW-1:0] w_w;
   logic [1:0][CW-1:0] w_cnt;

   assign s_ready = !w_full[r_wsel];
   assign m_valid = w_full[r_rsel];
   assign w_acc   = s_valid && s_ready;
   assign w_close = w_acc && ((r_idx == IW'(N-1)) || s_last);
   assign w_drain = m_valid && m_ready;

   for (genvar g = 0; g < 2; g++) begin : g_slot
      operand_slot #(.N(N), .DW(DATA_WIDTH), .IW(IW), .CW(CW)) u_slot (
         .clk     (clk),
         .rst     (rst),
         .i_wr    (w_acc   && (r_wsel == 1'(g))),
         .i_close (w_close && (r_wsel == 1'(g))),
         .i_drain (w_drain && (r_rsel == 1'(g))),
         .i_lane  (r_idx),
         .i_x     (s_x),
         .i_w     (s_w),
         .o_full  (w_full[g]),
         .o_x     (w_x[g]),
         .o_w     (w_w[g]),
         .o_count (w_cnt[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wsel <= 1'b0;
         r_rsel <= 1'b0;
         r_idx  <= '0;
      end else begin
         if (w_acc)   r_idx  <= w_close ? '0 : r_idx + IW'(1);
         if (w_close) r_wsel <= ~r_wsel;
         if (w_drain) r_rsel <= ~r_rsel;
      end
   end

   // The read slot may be the one currently filling, so gate on m_valid.
   assign m_x     = m_valid ? w_x[r_rsel]   : '0;
   assign m_w     = m_valid ? w_w[r_rsel]   : '0;
   assign m_count = m_valid ? w_cnt[r_rsel] : '0;
endmodule

// File: tb/tb_dot_operand_loader.sv
// Self-checking bench for dot_operand_loader with a queue-based vector model.
module tb_dot_operand_loader;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int CW = $clog2(N+1);
   localparam int VW = N*DW;
   localparam int SW = 2 + CW + 2*VW;

   logic          clk = 1'b0;
   logic          rst, s_valid, s_ready, s_last, m_valid, m_ready;
   logic [DW-1:0] s_x, s_w;
   logic [VW-1:0] m_x, m_w;
   logic [CW-1:0] m_count;

   dot_operand_loader #(.N(N), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
      .s_x(s_x), .s_w(s_w), .s_last(s_last), .m_valid(m_valid),
      .m_ready(m_ready), .m_x(m_x), .m_w(m_w), .m_count(m_count)
   );

   always #5 clk = ~clk;

   typedef struct { logic [VW-1:0] x; logic [VW-1:0] w; int cnt; } vec_t;
   vec_t          pend[$];
   logic [DW-1:0] cx[N];
   logic [DW-1:0] cw[N];
   int            cur_n = 0;
   bit            acc, drn;
   logic [SW-1:0] obs, expv;
   int            ntests = 0;
   int            nfail = 0;

   function automatic logic [VW-1:0] packv(input logic [DW-1:0] e[N], input int n);
      logic [VW-1:0] r = '0;
      for (int i = 0; i < n; i++) r = r | (VW'(e[i]) << (i*DW));
      return r;
   endfunction

   // Drive one cycle, advance the model across the same edge, then snapshot both.
   task automatic tick(input logic v, input logic [DW-1:0] x, input logic [DW-1:0] w,
                       input logic l, input logic mr, input logic r = 1'b0);
      vec_t nv;
      rst = r; s_valid = v; s_x = x; s_w = w; s_last = l; m_ready = mr;
      if (r) begin
         pend.delete(); cur_n = 0; acc = 0; drn = 0;
      end else begin
         drn = (pend.size() > 0) && mr;
         acc = v && (pend.size() < 2);
         if (drn) void'(pend.pop_front());
         if (acc) begin
            cx[cur_n] = x; cw[cur_n] = w; cur_n++;
            if (cur_n == N || l) begin
               nv.x = packv(cx, cur_n); nv.w = packv(cw, cur_n); nv.cnt = cur_n;
               pend.push_back(nv);
               cur_n = 0;
            end
         end
      end
      @(posedge clk); @(negedge clk);
      obs = {s_ready, m_valid, m_count, m_x, m_w};
      if (pend.size() > 0)
         expv = {1'(pend.size() < 2), 1'b1, CW'(pend[0].cnt), pend[0].x, pend[0].w};
      else
         expv = {1'b1, 1'b0, {CW{1'b0}}, {VW{1'b0}}, {VW{1'b0}}};
   endtask

   task automatic test_reset();
      tick(0, 0, 0, 0, 0, 1);
      tick(0, 0, 0, 0, 0, 1);
      ntests++;
      if (obs !== {1'b1, {(SW-1){1'b0}}}) begin
         nfail++; $display("FAIL reset: got %h want %h", obs, {1'b1, {(SW-1){1'b0}}});
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < N; i++) begin
         tick(1, DW'(i+1), DW'(-(i+1)), 0, 1);
         ntests++;
         if (obs !== expv) begin nfail++; $display("FAIL basic_snap: got %h want %h", obs, expv); end
         if (i == N-2) begin
            ntests++;
            if (m_valid !== 1'b0) begin nfail++; $display("FAIL basic_early: m_valid got %b want 0", m_valid); end
         end
      end
      ntests++;
      if (m_valid !== 1'b1 || m_x !== 32'h04030201 || m_w !== 32'hFCFDFEFF || m_count !== 3'd4) begin
         nfail++;
         $display("FAIL basic_vec: got v=%b x=%h w=%h c=%0d want v=1 x=04030201 w=fcfdfeff c=4",
                  m_valid, m_x, m_w, m_count);
      end
      tick(0, 0, 0, 0, 1);
      ntests++;
      if (m_valid !== 1'b0) begin nfail++; $display("FAIL basic_drain: m_valid got %b want 0", m_valid); end
   endtask

   task automatic test_short();
      tick(1, 8'd5, 8'hFB, 0, 1);
      tick(1, 8'd6, 8'hFA, 1, 1);
      ntests++;
      if (m_valid !== 1'b1 || m_x !== 32'h00000605 || m_w !== 32'h0000FAFB || m_count !== 3'd2) begin
         nfail++;
         $display("FAIL short_vec: got v=%b x=%h w=%h c=%0d want v=1 x=00000605 w=0000fafb c=2",
                  m_valid, m_x, m_w, m_count);
      end
      tick(0, 0, 0, 0, 1);
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] px[12], pw[12], tx[N];
      logic [VW-1:0] got[$];
      logic [VW-1:0] want;
      int na = 0, t = 0, drain_t = -1, acc9_t = -1;
      for (int i = 0; i < 12; i++) begin px[i] = DW'($urandom); pw[i] = DW'($urandom); end
      while (na < 8 && t < 30) begin
         tick(1, px[na], pw[na], 0, 0);
         if (acc) na++;
         t++;
         ntests++;
         if (obs !== expv) begin nfail++; $display("FAIL bp_fill_snap: got %h want %h", obs, expv); end
      end
      ntests++;
      if (s_ready !== 1'b0) begin nfail++; $display("FAIL bp_sready: got %b want 0 after 8 accepts", s_ready); end
      for (int i = 0; i < N; i++) tx[i] = px[i];
      want = packv(tx, N);
      for (int k = 0; k < 3; k++) begin
         tick(1, px[8], pw[8], 0, 0);
         ntests++;
         if (s_ready !== 1'b0 || m_x !== want) begin
            nfail++; $display("FAIL bp_hold: got rdy=%b x=%h want rdy=0 x=%h", s_ready, m_x, want);
         end
      end
      t = 0;
      while ((na < 12 || m_valid) && t < 60) begin
         if (m_valid) got.push_back(m_x);
         tick(na < 12, px[na < 12 ? na : 0], pw[na < 12 ? na : 0], 0, 1);
         if (drn && drain_t < 0) drain_t = t;
         if (acc) begin if (na == 8) acc9_t = t; na++; end
         t++;
         ntests++;
         if (obs !== expv) begin nfail++; $display("FAIL bp_drain_snap: got %h want %h", obs, expv); end
      end
      ntests++;
      if (t >= 60) begin nfail++; $display("FAIL bp_timeout: got %0d cycles want <60", t); end
      ntests++;
      if (got.size() != 3) begin nfail++; $display("FAIL bp_count: got %0d vectors want 3", got.size()); end
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         for (int i = 0; i < N; i++) tx[i] = px[4*k+i];
         want = packv(tx, N);
         ntests++;
         if (got[k] !== want) begin nfail++; $display("FAIL bp_order: vec%0d got %h want %h", k, got[k], want); end
      end
      ntests++;
      if (drain_t < 0 || acc9_t <= drain_t) begin
         nfail++; $display("FAIL bp_acc9: got accept@%0d drain@%0d want accept after drain", acc9_t, drain_t);
      end
   endtask

   task automatic test_continuous();
      int vt[$];
      for (int t = 0; t < 34; t++) begin
         tick(t < 32, DW'($urandom), DW'($urandom), 0, 1);
         ntests++;
         if (obs !== expv) begin nfail++; $display("FAIL cont_snap: got %h want %h", obs, expv); end
         ntests++;
         if (s_ready !== 1'b1) begin nfail++; $display("FAIL cont_sready: cycle %0d got %b want 1", t, s_ready); end
         if (m_valid) vt.push_back(t);
      end
      ntests++;
      if (vt.size() != 8) begin nfail++; $display("FAIL cont_count: got %0d vectors want 8", vt.size()); end
      for (int k = 1; k < vt.size(); k++) begin
         ntests++;
         if (vt[k] - vt[k-1] != 4) begin nfail++; $display("FAIL cont_gap: got %0d want 4", vt[k]-vt[k-1]); end
      end
   endtask

   task automatic test_reset_midfill();
      logic [DW-1:0] wv[N];
      tick(1, 8'h77, 8'h55, 0, 0);
      tick(1, 8'h66, 8'h44, 0, 0);
      tick(0, 0, 0, 0, 0, 1);
      ntests++;
      if (obs !== {1'b1, {(SW-1){1'b0}}}) begin
         nfail++; $display("FAIL rmf_reset: got %h want %h", obs, {1'b1, {(SW-1){1'b0}}});
      end
      for (int i = 0; i < N; i++) begin wv[i] = DW'($urandom); tick(1, 8'd9, wv[i], 0, 0); end
      ntests++;
      if (m_valid !== 1'b1 || m_x !== 32'h09090909 || m_w !== packv(wv, N) || m_count !== 3'd4) begin
         nfail++;
         $display("FAIL rmf_vec: got v=%b x=%h w=%h c=%0d want v=1 x=09090909 w=%h c=4",
                  m_valid, m_x, m_w, m_count, packv(wv, N));
      end
      tick(0, 0, 0, 0, 1);
   endtask

   task automatic test_short_then_full();
      logic [DW-1:0] a[N], b[N];
      logic [DW-1:0] a0;
      for (int rep = 0; rep < 2; rep++) begin
         a0 = DW'($urandom_range(1, 255));
         tick(1, a0, DW'($urandom), 1, 1);
         ntests++;
         if (m_count !== 3'd1 || m_x !== VW'(a0)) begin
            nfail++; $display("FAIL sf_short: got x=%h c=%0d want x=%h c=1", m_x, m_count, VW'(a0));
         end
         for (int i = 0; i < N; i++) begin
            a[i] = DW'($urandom); b[i] = DW'($urandom);
            tick(1, a[i], b[i], 0, 1);
         end
         ntests++;
         if (m_x !== packv(a, N) || m_w !== packv(b, N) || m_count !== 3'd4) begin
            nfail++;
            $display("FAIL sf_full: got x=%h w=%h c=%0d want x=%h w=%h c=4",
                     m_x, m_w, m_count, packv(a, N), packv(b, N));
         end
         tick(0, 0, 0, 0, 1);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 400; t++) begin
         tick(($urandom % 4) != 0, DW'($urandom), DW'($urandom), ($urandom % 5) == 0,
              ($urandom % 3) != 0, ($urandom % 97) == 0);
         ntests++;
         if (obs !== expv) begin nfail++; $display("FAIL rand_snap: cycle %0d got %h want %h", t, obs, expv); end
      end
   endtask

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_x = '0; s_w = '0; s_last = 1'b0; m_ready = 1'b0;
      test_reset();
      test_basic();
      test_short();
      test_backpressure();
      test_continuous();
      test_reset_midfill();
      test_short_then_full();
      test_random();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
